// File: rtl/mult_pkg.sv
// Shared constants and elaboration helpers for pipelined_tree_multiplier.
// Dadda height sequence, row bookkeeping, Baugh-Wooley correction.
package mult_pkg;

  localparam int STAGES = 3;

  // d(0)=2, d(j+1)=floor(1.5*d(j)): 2,3,4,6,9,13,19,...
  function automatic int dadda_height(input int j);
    int d;
    d = 2;
    for (int k = 0; k < j; k++) d = (d * 3) / 2;
    return d;
  endfunction

  // Reduction levels needed to bring n rows down to two.
  function automatic int dadda_levels(input int n);
    int lv;
    lv = 0;
    for (int k = 0; k < 16; k++)
      if (dadda_height(k) < n) lv++;
    return lv;
  endfunction

  // Rows present at a level when every full triple is compressed.
  function automatic int rows_at(input int n0, input int lvl);
    int n;
    n = n0;
    for (int k = 0; k < lvl; k++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  // Offset of a level inside the flattened row array.
  function automatic int row_off(input int n0, input int lvl);
    int o;
    o = 0;
    for (int k = 0; k < lvl; k++) o += rows_at(n0, k);
    return o;
  endfunction

  // Baugh-Wooley constant: 2^w + 2^(2w-1).
  function automatic logic [31:0] bw_const(input int w);
    return (32'd1 << w) | (32'd1 << (2 * w - 1));
  endfunction

endpackage

// File: rtl/pipelined_tree_multiplier_if.sv
// Operand/result handshake bundle for pipelined_tree_multiplier.
// master: producer + result sink; slave: the multiplier.
interface pipelined_tree_multiplier_if #(
  parameter int WIDTH     = 5,
  parameter int OUT_WIDTH = 2 * WIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] result;
  logic                 overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/pipelined_tree_multiplier_csa_row.sv
// csa_row: N-bit row of 3:2 counters (half adders where cin_i=0).
// a_i, b_i, cin_i -> sum_o, carry_o (carry already weighted by 2).
module csa_row #(
  parameter int N = 10
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] cin_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] carry_o
);
  logic [N-1:0] maj;

  assign sum_o   = a_i ^ b_i ^ cin_i;
  assign maj     = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
  assign carry_o = maj << 1;
endmodule

// File: rtl/pipelined_tree_multiplier.sv
// 3-stage tree multiplier: S1 AND array, S2 CSA tree, S3 CPA.
// Ports: clock, resetn (async low), bus (slave); MULT_SIGNED_EN.
module pipelined_tree_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int OUT_WIDTH = 2 * WIDTH
) (
  input logic                       clock,
  input logic                       resetn,
  pipelined_tree_multiplier_if.slave bus
);

  localparam int PW = 2 * WIDTH;
`ifdef MULT_SIGNED_EN
  localparam int NROWS = WIDTH + 1;
`else
  localparam int NROWS = WIDTH;
`endif
  localparam int LEVELS = dadda_levels(NROWS);
  localparam int TOT    = row_off(NROWS, LEVELS + 1);
  localparam int FO     = row_off(NROWS, LEVELS);

  logic v1_q, v2_q, v3_q;
  logic ld1, ld2, ld3;

  logic [WIDTH-1:0][WIDTH-1:0] pp_d, pp_q;
  logic [PW-1:0]        sum_d, carry_d;
  logic [PW-1:0]        sum_q, carry_q;
  logic [PW-1:0]        prod;
  logic [OUT_WIDTH-1:0] result_d, result_q;
  logic                 ovf_d, ovf_q;

  // Each stage advances when empty or when its successor advances.
  assign ld3 = !v3_q || bus.out_ready;
  assign ld2 = !v2_q || ld3;
  assign ld1 = !v1_q || ld2;

  assign bus.in_ready  = ld1;
  assign bus.out_valid = v3_q;
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;

  always_comb begin
    pp_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_d[i][j] = bus.a[j] & bus.b[i];
`ifdef MULT_SIGNED_EN
        // Invert terms pairing exactly one sign bit.
        if ((i == WIDTH - 1) != (j == WIDTH - 1))
          pp_d[i][j] = ~pp_d[i][j];
`endif
      end
    end
  end

  // Flattened rows of all reduction levels; level 0 at offset 0.
  logic [PW-1:0] rw [TOT];

  for (genvar r = 0; r < WIDTH; r++) begin : g_pp
    assign rw[r] = {{WIDTH{1'b0}}, pp_q[r]} << r;
  end

`ifdef MULT_SIGNED_EN
  localparam logic [PW-1:0] BWC = PW'(bw_const(WIDTH));
  assign rw[WIDTH] = BWC;
`endif

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N  = rows_at(NROWS, l);
    localparam int IO = row_off(NROWS, l);
    localparam int OO = row_off(NROWS, l + 1);
    localparam int G  = N / 3;
    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_row #(.N(PW)) u_csa (
        .a_i    (rw[IO+3*g]),
        .b_i    (rw[IO+3*g+1]),
        .cin_i  (rw[IO+3*g+2]),
        .sum_o  (rw[OO+2*g]),
        .carry_o(rw[OO+2*g+1])
      );
    end
    for (genvar r = 3 * G; r < N; r++) begin : g_pass
      assign rw[OO+2*G+r-3*G] = rw[IO+r];
    end
  end

  assign sum_d   = rw[FO];
  assign carry_d = rw[FO+1];

  assign prod     = sum_q + carry_q;
  assign result_d = prod[OUT_WIDTH-1:0];

`ifdef MULT_SIGNED_EN
  // Fits only if dropped bits replicate the kept sign bit.
  assign ovf_d = !((&prod[PW-1:OUT_WIDTH-1]) ||
                   !(|prod[PW-1:OUT_WIDTH-1]));
`else
  if (OUT_WIDTH < PW) begin : g_ovf
    assign ovf_d = |prod[PW-1:OUT_WIDTH];
  end else begin : g_novf
    assign ovf_d = 1'b0;
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (ld1) v1_q <= bus.in_valid;
      if (ld2) v2_q <= v1_q;
      if (ld3) v3_q <= v2_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pp_q     <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (bus.in_valid && ld1) pp_q <= pp_d;
      if (v1_q && ld2) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
      if (v2_q && ld3) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Scoreboard bench: WIDTH=5 with OUT_WIDTH=10 and OUT_WIDTH=8 in lockstep.
// Honours MULT_SIGNED_EN for directed values and the reference model.
module tb_pipelined_tree_multiplier;

  localparam int W = 5;

  typedef struct {
    logic [9:0] r10;
    logic       ov10;
    logic [7:0] r8;
    logic       ov8;
    int         t;
    bit         lat;
  } exp_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rmode = 0;
  int bp0 = 0;
  bit saw_drop = 0;
  bit held_v = 0;
  logic [9:0] held_r = '0;
  logic held_o8 = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clock = ~clock;

  pipelined_tree_multiplier_if #(.WIDTH(W), .OUT_WIDTH(10)) bus10 ();
  pipelined_tree_multiplier_if #(.WIDTH(W), .OUT_WIDTH(8))  bus8 ();

  assign bus10.in_valid  = in_valid;
  assign bus10.a         = a;
  assign bus10.b         = b;
  assign bus10.out_ready = out_ready;
  assign bus8.in_valid   = in_valid;
  assign bus8.a          = a;
  assign bus8.b          = b;
  assign bus8.out_ready  = out_ready;

  pipelined_tree_multiplier #(.WIDTH(W), .OUT_WIDTH(10)) dut10 (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus10)
  );

  pipelined_tree_multiplier #(.WIDTH(W), .OUT_WIDTH(8)) dut8 (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus8)
  );

`ifdef MULT_SIGNED_EN
  int ta[7]  = '{'h10, 'h10, 'h0F, 'h1F, 'h1F, 'h00, 'h07};
  int tbv[7] = '{'h10, 'h0F, 'h0F, 'h1F, 'h01, 'h10, 'h17};
  int t10[7] = '{'h100, 'h310, 'h0E1, 'h001, 'h3FF, 'h000, 'h3C1};
  int t8[7]  = '{'h00, 'h10, 'hE1, 'h01, 'hFF, 'h00, 'hC1};
  int to8[7] = '{1, 1, 1, 0, 0, 0, 0};
`else
  int ta[7]  = '{31, 15, 0, 31, 1, 16, 7};
  int tbv[7] = '{31, 17, 31, 0, 1, 16, 9};
  int t10[7] = '{'h3C1, 'h0FF, 0, 0, 1, 'h100, 'h03F};
  int t8[7]  = '{'hC1, 'hFF, 0, 0, 1, 'h00, 'h3F};
  int to8[7] = '{1, 0, 0, 0, 0, 1, 0};
`endif

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [9:0] r10, input logic o10,
                              input logic [7:0] r8, input logic o8,
                              input bit lat);
    exp_t m;
    m.r10 = r10; m.ov10 = o10; m.r8 = r8; m.ov8 = o8;
    m.t = 0; m.lat = lat;
    return m;
  endfunction

  function automatic exp_t model(input logic [4:0] x, input logic [4:0] y,
                                 input bit lat);
    exp_t m;
    logic [9:0] p;
`ifdef MULT_SIGNED_EN
    p = 10'($signed({{5{x[4]}}, x}) * $signed({{5{y[4]}}, y}));
    m.ov8 = !(p[9:7] == 3'b000 || p[9:7] == 3'b111);
`else
    p = {5'd0, x} * {5'd0, y};
    m.ov8 = |p[9:8];
`endif
    m.r10 = p; m.ov10 = 1'b0; m.r8 = p[7:0];
    m.t = 0; m.lat = lat;
    return m;
  endfunction

  task automatic send(input logic [4:0] xa, input logic [4:0] xb,
                      input exp_t e);
    int n;
    bit acc;
    n = 0; acc = 0;
    in_valid = 1'b1; a = xa; b = xb;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = bus10.in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (acc) begin
      e.t = cyc;
      q.push_back(e);
    end else begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 required 1");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending required 0", q.size());
    end
  endtask

  // Result sink: out_ready pattern chosen by rmode.
  always @(posedge clock) begin
    #1;
    case (rmode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = !(cyc >= bp0 && cyc < bp0 + 4);
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: compare every delivered result against the queue head.
  always @(negedge clock) begin
    cyc++;
    if (!resetn) begin
      held_v = 0;
    end else begin
      if (rmode == 2 && !bus10.in_ready) saw_drop = 1;
      if (held_v) begin
        check("hold_valid", 32'(bus10.out_valid), 32'd1);
        check("hold_result", 32'(bus10.result), 32'(held_r));
        check("hold_ovf8", 32'(bus8.overflow), 32'(held_o8));
      end
      held_v  = bus10.out_valid && !out_ready;
      held_r  = bus10.result;
      held_o8 = bus8.overflow;
      if (bus10.out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0h required none",
                   bus10.result);
        end else begin
          mon_e = q.pop_front();
          check("result10", 32'(bus10.result), 32'(mon_e.r10));
          check("ovf10", 32'(bus10.overflow), 32'(mon_e.ov10));
          check("valid8", 32'(bus8.out_valid), 32'd1);
          check("result8", 32'(bus8.result), 32'(mon_e.r8));
          check("ovf8", 32'(bus8.overflow), 32'(mon_e.ov8));
          if (mon_e.lat) check("latency", 32'(cyc - mon_e.t), 32'd3);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] x, y;
    resetn = 1'b0;
    #3;
    check("rst_valid10", 32'(bus10.out_valid), 32'd0);
    check("rst_result10", 32'(bus10.result), 32'd0);
    check("rst_ovf10", 32'(bus10.overflow), 32'd0);
    check("rst_valid8", 32'(bus8.out_valid), 32'd0);
    check("rst_result8", 32'(bus8.result), 32'd0);
    check("rst_ovf8", 32'(bus8.overflow), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("rdy_after_rst", 32'(bus10.in_ready), 32'd1);

    // Directed vectors, back-to-back, sink always ready.
    for (int i = 0; i < 7; i++)
      send(5'(ta[i]), 5'(tbv[i]),
           mk(10'(t10[i]), 1'b0, 8'(t8[i]), 1'(to8[i]), 1'b1));
    idle();
    drain();

    // Back-pressure: 1..6 times 3, sink stalled for 4 cycles.
    bp0 = cyc + 2;
    rmode = 2;
    for (int k = 1; k <= 6; k++)
      send(5'(k), 5'd3, mk(10'(3 * k), 1'b0, 8'(3 * k), 1'b0, 1'b0));
    idle();
    drain();
    rmode = 0;
    check("in_ready_dropped", 32'(saw_drop), 32'd1);

    // Unstalled random stream: latency must be exactly 3.
    for (int i = 0; i < 20; i++) begin
      x = 5'($urandom_range(0, 31));
      y = 5'($urandom_range(0, 31));
      send(x, y, model(x, y, 1'b1));
    end
    idle();
    drain();

    // Reset with two products in flight.
    send(5'd3, 5'd5, model(5'd3, 5'd5, 1'b0));
    idle();
    drain();
    send(5'd7, 5'd7, model(5'd7, 5'd7, 1'b0));
    send(5'd9, 5'd9, model(5'd9, 5'd9, 1'b0));
    resetn = 1'b0;
    in_valid = 1'b0;
    #1;
    q.delete();
    check("mid_rst_valid", 32'(bus10.out_valid), 32'd0);
    check("mid_rst_result", 32'(bus10.result), 32'd0);
    check("mid_rst_result8", 32'(bus8.result), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("rdy_after_rst2", 32'(bus10.in_ready), 32'd1);
    repeat (8) @(posedge clock);
    #1;
    check("no_stale", 32'(bus10.out_valid), 32'd0);

    // Random operands, random gaps, random sink readiness.
    rmode = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 4) == 0) idle();
      x = 5'($urandom_range(0, 31));
      y = 5'($urandom_range(0, 31));
      send(x, y, model(x, y, 1'b0));
    end
    idle();
    rmode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
